// File: rtl/wt_cache_pkg.sv
// wt_cache_pkg -- the slice of the write-through cache package used by the
// L1.5 request arbiter: the L1.5 request record and request-type encodings,
// the D$ request-type encoding, the adapter FIFO depth, and the byte-swap and
// byte-enable-to-size helpers.
package wt_cache_pkg;

  localparam int unsigned L15_TID_WIDTH          = 2;
  localparam int unsigned L15_WAY_WIDTH          = 3;
  localparam int unsigned L15_TLB_CSM_WIDTH      = 33;
  localparam int unsigned ADAPTER_REQ_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    DCACHE_STORE_REQ  = 2'd0,
    DCACHE_LOAD_REQ   = 2'd1,
    DCACHE_ATOMIC_REQ = 2'd2,
    DCACHE_INT_REQ    = 2'd3
  } dcache_out_t;

  typedef enum logic [4:0] {
    L15_LOAD_RQ   = 5'b00000,
    L15_STORE_RQ  = 5'b00001,
    L15_ATOMIC_RQ = 5'b00110,
    L15_INT_RQ    = 5'b01001,
    L15_IMISS_RQ  = 5'b10000
  } l15_reqtypes_t;

  typedef struct packed {
    logic                         l15_val;
    logic                         l15_req_ack;
    l15_reqtypes_t                l15_rqtype;
    logic                         l15_nc;
    logic [2:0]                   l15_size;
    logic [L15_TID_WIDTH-1:0]     l15_threadid;
    logic                         l15_prefetch;
    logic                         l15_invalidate_cacheline;
    logic                         l15_blockstore;
    logic                         l15_blockinitstore;
    logic [L15_WAY_WIDTH-1:0]     l15_l1rplway;
    logic [39:0]                  l15_address;
    logic [63:0]                  l15_data;
    logic [63:0]                  l15_data_next_entry;
    logic [L15_TLB_CSM_WIDTH-1:0] l15_csm_data;
    logic [3:0]                   l15_amo_op;
  } l15_req_t;

  // Reverse the byte order of a doubleword.
  function automatic logic [63:0] swendian64(input logic [63:0] in);
    logic [63:0] out;
    for (int i = 0; i < 8; i++) begin
      out[8*i +: 8] = in[8*(7-i) +: 8];
    end
    return out;
  endfunction

  // Encode a naturally aligned byte-enable mask as a log2 access size.
  function automatic logic [1:0] toSize64(input logic [7:0] be);
    logic [1:0] size;
    case (be)
      8'hff:                      size = 2'b11;
      8'h0f, 8'hf0:               size = 2'b10;
      8'h03, 8'h0c, 8'h30, 8'hc0: size = 2'b01;
      default:                    size = 2'b00;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/wt_l15_req_fifo.sv
// wt_l15_req_fifo -- registered circular FIFO, no fall-through.
//   clk_i, rst_ni  : clock, asynchronous active-low reset (control only)
//   push_i, data_i : write an entry (ignored while full)
//   pop_i          : drop the head entry (ignored while empty)
//   data_o         : head entry, meaningful only while !empty_o
//   full_o/empty_o : occupancy flags
module wt_l15_req_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt == CNT_W'(DEPTH));
  assign empty_o = (cnt == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; the occupancy count alone decides validity.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= data_i;
    end
  end

endmodule

// File: rtl/wt_l15_req_arb.sv
// wt_l15_req_arb -- arbitrates I$ fill requests and D$ requests onto the
// single L1.5 request port through a small registered FIFO.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   icache_req_*           : I$ fill request (valid/ready, paddr, nc, tid)
//   dcache_req_*           : D$ request (valid/ready, type, paddr, data, be,
//                            nc, tid, amo_op, way)
//   l15_req_o              : request record to the L1.5; l15_val = FIFO non-empty
//   l15_header_ack_i       : L1.5 accepted the head request
// Build option: define WT_L15_REQ_SWENDIAN_EN to byte-swap D$ write data as
// it enters the FIFO.
module wt_l15_req_arb
  import wt_cache_pkg::*;
#(
  parameter int unsigned TID_W      = 2,
  parameter int unsigned WAY_W      = 3,
  parameter int unsigned FIFO_DEPTH = ADAPTER_REQ_FIFO_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             icache_req_valid_i,
  output logic             icache_req_ready_o,
  input  logic [39:0]      icache_req_paddr_i,
  input  logic             icache_req_nc_i,
  input  logic [TID_W-1:0] icache_req_tid_i,
  input  logic             dcache_req_valid_i,
  output logic             dcache_req_ready_o,
  input  logic [1:0]       dcache_req_type_i,
  input  logic [39:0]      dcache_req_paddr_i,
  input  logic [63:0]      dcache_req_data_i,
  input  logic [7:0]       dcache_req_be_i,
  input  logic             dcache_req_nc_i,
  input  logic [TID_W-1:0] dcache_req_tid_i,
  input  logic [3:0]       dcache_req_amo_op_i,
  input  logic [WAY_W-1:0] dcache_req_way_i,
  output l15_req_t         l15_req_o,
  input  logic             l15_header_ack_i
);

  localparam logic RR_DCACHE = 1'b0;
  localparam logic RR_ICACHE = 1'b1;

  logic     rr_ptr;
  logic     fifo_full;
  logic     fifo_empty;
  logic     dcache_gnt;
  logic     icache_gnt;
  logic     vld_p0;
  logic     pop_p1;
  l15_req_t req_p0;
  l15_req_t head_p1;

  // The side the pointer does not favour only sees ready when the favoured
  // side is idle, so at most one handshake completes per cycle.
  assign dcache_req_ready_o = !fifo_full && ((rr_ptr == RR_DCACHE) || !icache_req_valid_i);
  assign icache_req_ready_o = !fifo_full && ((rr_ptr == RR_ICACHE) || !dcache_req_valid_i);
  assign dcache_gnt         = dcache_req_valid_i && dcache_req_ready_o;
  assign icache_gnt         = icache_req_valid_i && icache_req_ready_o;
  assign vld_p0             = dcache_gnt || icache_gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= RR_DCACHE;
    end else if (dcache_gnt) begin
      rr_ptr <= RR_ICACHE;
    end else if (icache_gnt) begin
      rr_ptr <= RR_DCACHE;
    end
  end

  // ---- p0: format the granted request into an L1.5 record ----
  always_comb begin
    req_p0 = '0;
    if (dcache_gnt) begin
      case (dcache_out_t'(dcache_req_type_i))
        DCACHE_STORE_REQ:  req_p0.l15_rqtype = L15_STORE_RQ;
        DCACHE_LOAD_REQ:   req_p0.l15_rqtype = L15_LOAD_RQ;
        DCACHE_ATOMIC_REQ: req_p0.l15_rqtype = L15_ATOMIC_RQ;
        DCACHE_INT_REQ:    req_p0.l15_rqtype = L15_INT_RQ;
      endcase
      req_p0.l15_nc       = dcache_req_nc_i;
      req_p0.l15_size     = {1'b0, toSize64(dcache_req_be_i)};
      req_p0.l15_threadid = L15_TID_WIDTH'(dcache_req_tid_i);
      req_p0.l15_l1rplway = L15_WAY_WIDTH'(dcache_req_way_i);
      req_p0.l15_address  = dcache_req_paddr_i;
`ifdef WT_L15_REQ_SWENDIAN_EN
      req_p0.l15_data     = swendian64(dcache_req_data_i);
`else
      req_p0.l15_data     = dcache_req_data_i;
`endif
      req_p0.l15_amo_op   = dcache_req_amo_op_i;
    end else begin
      // I$ fills are whole cache lines: line-aligned address, maximum size.
      req_p0.l15_rqtype   = L15_IMISS_RQ;
      req_p0.l15_nc       = icache_req_nc_i;
      req_p0.l15_size     = 3'b111;
      req_p0.l15_threadid = L15_TID_WIDTH'(icache_req_tid_i);
      req_p0.l15_address  = icache_req_paddr_i & ~40'h1f;
    end
  end

  // ---- p0 -> p1: request FIFO ----
  wt_l15_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (l15_req_t)
  ) i_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (vld_p0),
    .data_i  (req_p0),
    .pop_i   (pop_p1),
    .data_o  (head_p1),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---- p1: present the head; zeros whenever nothing is queued ----
  assign pop_p1 = !fifo_empty && l15_header_ack_i;

  always_comb begin
    l15_req_o = '0;
    if (!fifo_empty) begin
      l15_req_o         = head_p1;
      l15_req_o.l15_val = 1'b1;
    end
  end

endmodule

// File: tb/tb_wt_l15_req_arb.sv
module tb_wt_l15_req_arb;
  import wt_cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        icache_req_valid;
  logic        icache_req_ready;
  logic [39:0] icache_req_paddr;
  logic        icache_req_nc;
  logic [1:0]  icache_req_tid;
  logic        dcache_req_valid;
  logic        dcache_req_ready;
  logic [1:0]  dcache_req_type;
  logic [39:0] dcache_req_paddr;
  logic [63:0] dcache_req_data;
  logic [7:0]  dcache_req_be;
  logic        dcache_req_nc;
  logic [1:0]  dcache_req_tid;
  logic [3:0]  dcache_req_amo_op;
  logic [2:0]  dcache_req_way;
  l15_req_t    l15_req;
  logic        l15_header_ack;

  wt_l15_req_arb #(
    .TID_W      (2),
    .WAY_W      (3),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .icache_req_valid_i  (icache_req_valid),
    .icache_req_ready_o  (icache_req_ready),
    .icache_req_paddr_i  (icache_req_paddr),
    .icache_req_nc_i     (icache_req_nc),
    .icache_req_tid_i    (icache_req_tid),
    .dcache_req_valid_i  (dcache_req_valid),
    .dcache_req_ready_o  (dcache_req_ready),
    .dcache_req_type_i   (dcache_req_type),
    .dcache_req_paddr_i  (dcache_req_paddr),
    .dcache_req_data_i   (dcache_req_data),
    .dcache_req_be_i     (dcache_req_be),
    .dcache_req_nc_i     (dcache_req_nc),
    .dcache_req_tid_i    (dcache_req_tid),
    .dcache_req_amo_op_i (dcache_req_amo_op),
    .dcache_req_way_i    (dcache_req_way),
    .l15_req_o           (l15_req),
    .l15_header_ack_i    (l15_header_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rq;
    logic [2:0]  size;
    logic [39:0] addr;
    logic [63:0] data;
    logic        nc;
    logic [1:0]  tid;
    logic [3:0]  amo;
    logic [2:0]  way;
  } exp_t;

  typedef struct {
    logic [1:0]  typ;
    logic [39:0] paddr;
    logic [63:0] data;
    logic [7:0]  be;
    logic        nc;
    logic [1:0]  tid;
    logic [3:0]  amo;
    logic [2:0]  way;
    logic [4:0]  x_rq;
    logic [2:0]  x_size;
    logic [63:0] x_swapped;
  } dvec_t;

  typedef struct {
    logic [39:0] paddr;
    logic        nc;
    logic [1:0]  tid;
    logic [39:0] x_addr;
  } ivec_t;

  dvec_t dv [8];
  ivec_t iv [3];
  exp_t  sb_q [$];
  exp_t  mon_e;
  int    checks = 0;
  int    errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  function automatic logic [63:0] exp_data(input int i);
`ifdef WT_L15_REQ_SWENDIAN_EN
    return dv[i].x_swapped;
`else
    return dv[i].data;
`endif
  endfunction

  task automatic push_d(input int i);
    exp_t e;
    e.rq = dv[i].x_rq; e.size = dv[i].x_size; e.addr = dv[i].paddr;
    e.data = exp_data(i); e.nc = dv[i].nc; e.tid = dv[i].tid;
    e.amo = dv[i].amo; e.way = dv[i].way;
    sb_q.push_back(e);
  endtask

  task automatic push_i(input int i);
    exp_t e;
    e.rq = 5'b10000; e.size = 3'b111; e.addr = iv[i].x_addr; e.data = 64'h0;
    e.nc = iv[i].nc; e.tid = iv[i].tid; e.amo = 4'h0; e.way = 3'd0;
    sb_q.push_back(e);
  endtask

  task automatic drive_d(input int i);
    dcache_req_type = dv[i].typ; dcache_req_paddr = dv[i].paddr;
    dcache_req_data = dv[i].data; dcache_req_be = dv[i].be;
    dcache_req_nc = dv[i].nc; dcache_req_tid = dv[i].tid;
    dcache_req_amo_op = dv[i].amo; dcache_req_way = dv[i].way;
  endtask

  task automatic drive_i(input int i);
    icache_req_paddr = iv[i].paddr; icache_req_nc = iv[i].nc; icache_req_tid = iv[i].tid;
  endtask

  // Offer one D$ request alone; optionally check it is not visible in its
  // acceptance cycle but is visible in the next one.
  task automatic send_d(input int i, input bit lat);
    bit ok = 1'b0;
    drive_d(i);
    dcache_req_valid = 1'b1;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (dcache_req_ready) begin
        ok = 1'b1;
        if (lat) chk("latency_same_cycle_val", 64'(l15_req.l15_val), 64'd0);
      end
      @(posedge clk); #1;
    end
    dcache_req_valid = 1'b0;
    chk("send_accepted", 64'(ok), 64'd1);
    if (ok) begin
      push_d(i);
      if (lat) begin
        @(negedge clk);
        chk("latency_next_cycle_val", 64'(l15_req.l15_val), 64'd1);
      end
    end
  endtask

  // Hold I$ and D$ valid together; each source advances to its next vector
  // after each of its handshakes, n vectors per source.
  task automatic arb_run(input int dbase, input int ibase, input int n);
    int  dn = 0;
    int  in_ = 0;
    bit  dh, ih;
    drive_d(dbase); drive_i(ibase);
    dcache_req_valid = 1'b1; icache_req_valid = 1'b1;
    for (int c = 0; c < 40 && (dn < n || in_ < n); c++) begin
      @(negedge clk);
      dh = dcache_req_valid && dcache_req_ready;
      ih = icache_req_valid && icache_req_ready;
      if (dcache_req_valid && icache_req_valid)
        chk("one_grant_when_both_valid", 64'(dh ^ ih), 64'd1);
      @(posedge clk); #1;
      if (dh) begin
        dn++;
        if (dn < n) drive_d(dbase + dn); else dcache_req_valid = 1'b0;
      end
      if (ih) begin
        in_++;
        if (in_ < n) drive_i(ibase + in_); else icache_req_valid = 1'b0;
      end
    end
    dcache_req_valid = 1'b0; icache_req_valid = 1'b0;
    chk("arb_all_accepted", 64'(dn + in_), 64'(2 * n));
  endtask

  task automatic drain();
    for (int c = 0; c < 50 && sb_q.size() != 0; c++) @(negedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: every header handshake must match the oldest
  // outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && l15_req.l15_val && l15_header_ack) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_issue_addr", 64'(l15_req.l15_address), 64'hffff_ffff_ffff_ffff);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rqtype",   64'(l15_req.l15_rqtype),   64'(mon_e.rq));
        chk("size",     64'(l15_req.l15_size),     64'(mon_e.size));
        chk("address",  64'(l15_req.l15_address),  64'(mon_e.addr));
        chk("data",     l15_req.l15_data,          mon_e.data);
        chk("nc",       64'(l15_req.l15_nc),       64'(mon_e.nc));
        chk("threadid", 64'(l15_req.l15_threadid), 64'(mon_e.tid));
        chk("amo_op",   64'(l15_req.l15_amo_op),   64'(mon_e.amo));
        chk("l1rplway", 64'(l15_req.l15_l1rplway), 64'(mon_e.way));
        chk("const_zero_fields",
            64'(l15_req.l15_req_ack | l15_req.l15_prefetch | l15_req.l15_invalidate_cacheline |
                l15_req.l15_blockstore | l15_req.l15_blockinitstore |
                (|l15_req.l15_data_next_entry) | (|l15_req.l15_csm_data)), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          typ   paddr            data                    be     nc    tid   amo   way   rq        size    swapped data
    dv[0] = '{2'd0, 40'h0080001008, 64'h1122334455667788, 8'h0f, 1'b0, 2'd1, 4'h0, 3'd0, 5'b00001, 3'b010, 64'h8877665544332211};
    dv[1] = '{2'd1, 40'h0090000010, 64'h0000000000000000, 8'hff, 1'b1, 2'd0, 4'h0, 3'd2, 5'b00000, 3'b011, 64'h0000000000000000};
    dv[2] = '{2'd0, 40'h0090000022, 64'h000000000000beef, 8'h03, 1'b0, 2'd1, 4'h0, 3'd7, 5'b00001, 3'b001, 64'hefbe000000000000};
    dv[3] = '{2'd2, 40'h0080002000, 64'hdeadbeef00000001, 8'hff, 1'b0, 2'd2, 4'h3, 3'd5, 5'b00110, 3'b011, 64'h01000000efbeadde};
    dv[4] = '{2'd3, 40'h00000000f0, 64'h0000000000000000, 8'h01, 1'b1, 2'd3, 4'h0, 3'd0, 5'b01001, 3'b000, 64'h0000000000000000};
    dv[5] = '{2'd0, 40'h0080003004, 64'h0102030405060708, 8'hf0, 1'b0, 2'd0, 4'h0, 3'd1, 5'b00001, 3'b010, 64'h0807060504030201};
    dv[6] = '{2'd1, 40'h0080003002, 64'h00000000ffff0000, 8'h0c, 1'b0, 2'd1, 4'h0, 3'd3, 5'b00000, 3'b001, 64'h0000ffff00000000};
    dv[7] = '{2'd0, 40'h0080004000, 64'hcafef00d12345678, 8'hff, 1'b0, 2'd2, 4'h0, 3'd1, 5'b00001, 3'b011, 64'h785634120df0feca};
    iv[0] = '{40'h001234567f, 1'b0, 2'd2, 40'h0012345660};
    iv[1] = '{40'h00abcdef1f, 1'b1, 2'd3, 40'h00abcdef00};
    iv[2] = '{40'h0080000fff, 1'b0, 2'd1, 40'h0080000fe0};

    icache_req_valid = 1'b0; dcache_req_valid = 1'b0; l15_header_ack = 1'b0;
    drive_d(0); drive_i(0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_val", 64'(l15_req.l15_val), 64'd0);
    chk("reset_fields_zero", 64'(l15_req == '0), 64'd1);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_dcache_ready", 64'(dcache_req_ready), 64'd1);
    chk("post_reset_icache_ready", 64'(icache_req_ready), 64'd1);
    chk("post_reset_val", 64'(l15_req.l15_val), 64'd0);
    @(posedge clk); #1;

    // Arbitration: expected issue order D$, I$, D$, I$
    l15_header_ack = 1'b1;
    push_d(1); push_i(0); push_d(2); push_i(1);
    arb_run(1, 0, 2);
    drain();

    // Single store with latency check, then atomic
    send_d(0, 1'b1);
    drain();
    send_d(3, 1'b0);
    drain();

    // Backpressure: two accepted, third held off while the head stays put
    l15_header_ack = 1'b0;
    send_d(4, 1'b0);
    send_d(5, 1'b0);
    drive_d(6);
    dcache_req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_ready_low_when_full", 64'(dcache_req_ready), 64'd0);
      chk("bp_head_addr_stable", 64'(l15_req.l15_address), 64'(dv[4].paddr));
      chk("bp_head_data_stable", l15_req.l15_data, exp_data(4));
      chk("bp_head_rqtype_stable", 64'(l15_req.l15_rqtype), 64'(dv[4].x_rq));
    end
    @(posedge clk); #1;
    l15_header_ack = 1'b1;
    @(negedge clk);
    chk("bp_ready_low_during_pop", 64'(dcache_req_ready), 64'd0);
    @(posedge clk); #1;
    l15_header_ack = 1'b0;
    @(negedge clk);
    chk("bp_ready_after_one_pop", 64'(dcache_req_ready), 64'd1);
    chk("bp_head_after_one_pop", 64'(l15_req.l15_address), 64'(dv[5].paddr));
    @(posedge clk); #1;
    dcache_req_valid = 1'b0;
    push_d(6);
    @(negedge clk);
    chk("two_queued_full", 64'(dcache_req_ready), 64'd0);
    chk("two_queued_val", 64'(l15_req.l15_val), 64'd1);

    // Reset with two entries queued: everything queued is discarded
    @(posedge clk); #3;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("mid_reset_val_drops", 64'(l15_req.l15_val), 64'd0);
    chk("mid_reset_fields_zero", 64'(l15_req == '0), 64'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    l15_header_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("after_reset_no_stale_val", 64'(l15_req.l15_val), 64'd0);
      chk("after_reset_dcache_ready", 64'(dcache_req_ready), 64'd1);
    end
    @(posedge clk); #1;
    // Pointer must favour D$ again
    push_d(7); push_i(2);
    arb_run(7, 2, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wt_l15_req_arb.md
WT_L15_REQ_ARB -- requirements
Module: wt_l15_req_arb

Interface
REQ-001 Parameter TID_W, default 2: transaction-ID width, equal to the memory TID width.
REQ-002 Parameter WAY_W, default 3: replacement-way width, equal to the D$ set-associativity width.
REQ-003 Parameter FIFO_DEPTH, default 2: request FIFO depth, equal to ADAPTER_REQ_FIFO_DEPTH.
REQ-004 clk_i  in  1  single clock, rising edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 icache_req_valid_i / icache_req_ready_o  in/out  1/1  I$ fill-request handshake.
REQ-007 icache_req_paddr_i  in  40  fill physical address.
REQ-008 icache_req_nc_i  in  1  fill non-cacheable.
REQ-009 icache_req_tid_i  in  TID_W  fill transaction ID.
REQ-010 dcache_req_valid_i / dcache_req_ready_o  in/out  1/1  D$ request handshake.
REQ-011 dcache_req_type_i  in  2  dcache_out_t.
REQ-012 dcache_req_paddr_i  in  40  D$ physical address.
REQ-013 dcache_req_data_i  in  64  D$ write data.
REQ-014 dcache_req_be_i  in  8  D$ byte enables.
REQ-015 dcache_req_nc_i  in  1  D$ non-cacheable.
REQ-016 dcache_req_tid_i  in  TID_W  D$ transaction ID.
REQ-017 dcache_req_amo_op_i  in  4  D$ AMO operation.
REQ-018 dcache_req_way_i  in  WAY_W  D$ replacement way.
REQ-019 l15_req_o  out  l15_req_t  request to the L1.5.
REQ-020 l15_header_ack_i  in  1  L1.5 header acceptance.

Function
- REQ-021 Handshake: a source is accepted on a cycle where its valid and ready are both high.
- REQ-022 Ready: icache_req_ready_o and dcache_req_ready_o SHALL be low whenever the FIFO is full.
- REQ-023 Grant: at most one source is granted per cycle, by a 1-bit round-robin pointer.
- REQ-024 Pointer: after each grant the pointer moves to the other source; it resets to favour the D$.
- REQ-025 Losing source: when both sources are valid, the losing source's ready SHALL be low.
- REQ-026 FIFO: the granted request is written into a FIFO_DEPTH-entry registered FIFO with no fall-through.
- REQ-027 Latency: a request accepted in cycle N appears on l15_req_o no earlier than cycle N+1.
- REQ-028 Valid: l15_req_o.l15_val SHALL equal FIFO non-empty.
- REQ-029 Pop: the FIFO head pops on l15_val && l15_header_ack_i.
- REQ-030 Stability: all l15_req_o fields SHALL hold stable from assertion of l15_val until header ack.
- REQ-031 Push while full: push uses pre-pop fullness, so no push occurs when full, even if a pop happens that cycle.
- REQ-032 Request type mapping:
  - I$ -> L15_IMISS_RQ
  - DCACHE_STORE_REQ -> L15_STORE_RQ
  - DCACHE_LOAD_REQ -> L15_LOAD_RQ
  - DCACHE_ATOMIC_REQ -> L15_ATOMIC_RQ
  - DCACHE_INT_REQ -> L15_INT_RQ
- REQ-033 Size: I$ l15_size = 3'b111; D$ l15_size = {1'b0, toSize64(be)}.
- REQ-034 Address: I$ l15_address SHALL be paddr with bits [4:0] zeroed; D$ address passes unmodified.
- REQ-035 D$ field pass-through: data, nc, tid (l15_threadid), amo_op and way (l15_l1rplway) pass through for D$ requests.
- REQ-036 I$ field defaults: data, amo_op and way are zero for I$ requests.
- REQ-037 Constant-zero fields: l15_req_ack, prefetch, invalidate_cacheline, blockstore, blockinitstore, data_next_entry and csm_data SHALL be constant zero.

Reset
- REQ-038 While rst_ni is low:
  - FIFO empty, so l15_val = 0.
  - Round-robin pointer at D$.
  - All l15_req_o fields zero.
  - Both readys high after release.
- REQ-039 Reset asserted mid-transaction SHALL discard all queued entries without issuing an ack.

Configuration
- REQ-040 With WT_L15_REQ_SWENDIAN_EN defined, D$ l15_data SHALL be swendian64(dcache_req_data_i) applied at FIFO write.
- REQ-041 Without WT_L15_REQ_SWENDIAN_EN, D$ data passes unswapped; all other behaviour is identical.

Structure
- REQ-042 The following stay in wt_cache_pkg; no new package types are introduced:
  - l15_req_t, l15_reqtypes_t, dcache_out_t
  - ADAPTER_REQ_FIFO_DEPTH
  - swendian64, toSize64
- REQ-043 One sub-module, wt_l15_req_fifo (depth/type parameterised, push/pop/full/empty), SHALL hold the queue.

Verification
- REQ-044 Single store: store, paddr 0x80001008, be 0x0F, data 0x1122334455667788, tid 1.
  - Next cycle: l15_val = 1, rqtype 5'b00001, size 3'b010, address 0x80001008, tid 1.
  - Swap disabled: data 0x1122334455667788; swap enabled: 0x8877665544332211.
- REQ-045 Arbitration: I$ and D$ held valid continuously, header_ack always high.
  - Issue order D$, I$, D$, I$.
  - I$ address has [4:0] = 0 and size 3'b111.
- REQ-046 Backpressure: header_ack low, 3 D$ requests offered.
  - Two accepted, then dcache_req_ready_o = 0.
  - Head payload unchanged for 10 cycles.
  - One ack pops exactly one entry; ready rises the following cycle.
- REQ-047 Atomic: atomic, amo_op 4'h3, be 0xFF, way 5.
  - rqtype 5'b00110, size 3'b011, l15_amo_op 3, l15_l1rplway 5.
- REQ-048 Reset mid-operation: reset asserted with 2 entries queued.
  - l15_val drops immediately.
  - After release no stale entry issues; pointer favours D$.
